// File: rtl/ff_pkg.sv
// Shared types and encodings for the JK excitation generator.
package ff_pkg;

  // Transfer sequencing: wait for a target, drive excitation, verify readback.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Excitation encodings, packed as {j,k}.
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] TOG  = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: maps the current and requested flip-flop value to {j,k}.
module jk_excite_bit
  import ff_pkg::*;
#(
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic       cur_i,
  input  logic       nxt_i,
  output logic [1:0] jk_o
);

  // Unchanged bits hold; changing bits either toggle or get an explicit set/reset.
  always_comb begin
    jk_o = HOLD;
    case ({cur_i, nxt_i})
      2'b01:   jk_o = USE_TOGGLE ? TOG : SET;
      2'b10:   jk_o = USE_TOGGLE ? TOG : RST;
      default: jk_o = HOLD;
    endcase
  end

endmodule

// File: rtl/jk_excite_gen.sv
// Drives J/K excitation to an external JK flip-flop bank so it reaches a
// requested target word, then reads the bank back and confirms the transfer.
module jk_excite_gen
  import ff_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int USE_TOGGLE = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [WIDTH-1:0]   j_q, j_d;
  logic [WIDTH-1:0]   k_q, k_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               checking;
  logic               match;
  logic [WIDTH-1:0]   exc_j;
  logic [WIDTH-1:0]   exc_k;

  // Excitation is computed from the incoming target against the live readback.
  // The bank holds still while idle (j=k=0), so the readback seen at accept is
  // the same value the bank presents throughout the DRIVE cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] jk_bit;
      jk_excite_bit #(
        .USE_TOGGLE (USE_TOGGLE != 0)
      ) u_bit (
        .cur_i (q_fb[gi]),
        .nxt_i (tgt[gi]),
        .jk_o  (jk_bit)
      );
      assign exc_j[gi] = jk_bit[1];
      assign exc_k[gi] = jk_bit[0];
    end
  endgenerate

  assign accept   = tgt_valid && tgt_ready;
  assign checking = (state_q == CHECK);
  assign match    = (q_fb == tgt_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one DRIVE cycle and one CHECK cycle per accepted target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready only while idle, and held low throughout reset.
  always_comb begin
    tgt_ready = (state_q == IDLE) && !rst;
  end

  // Datapath next values: capture, excitation, verification result, counter, sticky error.
  always_comb begin
    tgt_d  = accept ? tgt : tgt_q;
    j_d    = accept ? exc_j : '0;
    k_d    = accept ? exc_k : '0;
    done_d = checking;
    cnt_d  = (checking && match) ? cnt_q + CNT_W'(1) : cnt_q;
    // A mismatch on the same edge as a clear request keeps the flag set.
    if (checking && !match) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Datapath registers; reset discards any in-flight transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q  <= '0;
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tgt_q  <= tgt_d;
      j_q    <= j_d;
      k_q    <= k_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign j        = j_q;
  assign k        = k_q;
  assign done     = done_q;
  assign err      = err_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_jk_excite_gen.sv
// Scoreboard bench: two generators (set/reset mapping with 8-bit counter, toggle
// mapping with 2-bit counter) each drive their own behavioural JK bank.
module tb_jk_excite_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic       err_clr;
  logic [3:0] tgt;
  logic [3:0] stuck;

  logic       rdy0, rdy1;
  logic [3:0] j0, k0, j1, k1;
  logic       done0, done1, err0, err1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  logic [3:0] bank0 = 4'b0000;
  logic [3:0] bank1 = 4'b0000;
  logic [3:0] q_fb0, q_fb1;

  always #5 clk = ~clk;

  // Behavioural JK banks: Q+ = J&~Q | ~K&Q, read back through a stuck-at-0 mask.
  always @(posedge clk) begin
    bank0 <= (j0 & ~bank0) | (~k0 & bank0);
    bank1 <= (j1 & ~bank1) | (~k1 & bank1);
  end
  assign q_fb0 = bank0 & ~stuck;
  assign q_fb1 = bank1 & ~stuck;

  jk_excite_gen #(.WIDTH(4), .USE_TOGGLE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
    .j(j0), .k(k0), .q_fb(q_fb0), .done(done0), .err(err0), .err_clr(err_clr),
    .xfer_cnt(cnt0));

  jk_excite_gen #(.WIDTH(4), .USE_TOGGLE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
    .j(j1), .k(k1), .q_fb(q_fb1), .done(done1), .err(err1), .err_clr(err_clr),
    .xfer_cnt(cnt1));

  typedef struct packed {
    logic [3:0] ej0, ek0, ej1, ek1;
    logic       m0, m1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  time  last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] want_j(input logic [3:0] cur, input logic [3:0] nxt, input bit tog);
    if (tog) return cur ^ nxt;
    return nxt & ~cur;
  endfunction

  function automatic logic [3:0] want_k(input logic [3:0] cur, input logic [3:0] nxt, input bit tog);
    if (tog) return cur ^ nxt;
    return cur & ~nxt;
  endfunction

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj, input logic [3:0] kk);
    return (jj & ~q) | (~kk & q);
  endfunction

  // Offer a target; returns 1ns after the accepting edge (inside DRIVE).
  task automatic send(input logic [3:0] t, input bit hold, input bit check_spacing);
    int   n;
    exp_t e;
    tgt       = t;
    tgt_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      chk("handshake_timeout", 32'(rdy0), 32'd1);
    end else begin
      @(posedge clk);
      e.ej0 = want_j(q_fb0, t, 1'b0);
      e.ek0 = want_k(q_fb0, t, 1'b0);
      e.ej1 = want_j(q_fb1, t, 1'b1);
      e.ek1 = want_k(q_fb1, t, 1'b1);
      e.m0  = ((jk_next(bank0, e.ej0, e.ek0) & ~stuck) == t);
      e.m1  = ((jk_next(bank1, e.ej1, e.ek1) & ~stuck) == t);
      sb.push_back(e);
      if (check_spacing) chk("stream_spacing", 32'(($time - last_acc) / 10), 32'd3);
      last_acc = $time;
    end
    #1;
    if (!hold) tgt_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs each cycle against the scoreboard head and
  // the bench's own err/counter model.
  bit         rst_seen = 1'b0;
  int         stage    = 0;
  bit         exp_done = 1'b0;
  bit         exp_err0 = 1'b0, exp_err1 = 1'b0;
  logic [7:0] exp_cnt0 = 8'd0;
  logic [1:0] exp_cnt1 = 2'd0;
  bit         set0, set1, chk_edge;

  always @(negedge clk) begin
    set0 = 1'b0; set1 = 1'b0; chk_edge = 1'b0;
    if (rst) begin
      chk("ready_in_reset0", 32'(rdy0), 32'd0);
      chk("ready_in_reset1", 32'(rdy1), 32'd0);
      if (rst_seen) begin
        chk("reset_jk0", 32'({j0, k0}), 32'd0);
        chk("reset_jk1", 32'({j1, k1}), 32'd0);
        chk("reset_done", 32'({done0, done1}), 32'd0);
        chk("reset_err", 32'({err0, err1}), 32'd0);
        chk("reset_cnt", 32'({cnt0, cnt1}), 32'd0);
      end
      sb.delete();
      stage = 0; exp_done = 1'b0;
      exp_err0 = 1'b0; exp_err1 = 1'b0;
      exp_cnt0 = 8'd0; exp_cnt1 = 2'd0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      chk("done0", 32'(done0), 32'(exp_done));
      chk("done1", 32'(done1), 32'(exp_done));
      chk("err0", 32'(err0), 32'(exp_err0));
      chk("err1", 32'(err1), 32'(exp_err1));
      chk("cnt0", 32'(cnt0), 32'(exp_cnt0));
      chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
      if (sb.size() != 0 && stage == 0) begin
        chk("drive_j0", 32'(j0), 32'(sb[0].ej0));
        chk("drive_k0", 32'(k0), 32'(sb[0].ek0));
        chk("drive_j1", 32'(j1), 32'(sb[0].ej1));
        chk("drive_k1", 32'(k1), 32'(sb[0].ek1));
        chk("drive_ready", 32'({rdy0, rdy1}), 32'd0);
        stage = 1;
      end else if (stage == 1) begin
        chk("check_jk0", 32'({j0, k0}), 32'd0);
        chk("check_jk1", 32'({j1, k1}), 32'd0);
        chk("check_ready", 32'({rdy0, rdy1}), 32'd0);
        if (sb[0].m0) exp_cnt0 = exp_cnt0 + 8'd1; else set0 = 1'b1;
        if (sb[0].m1) exp_cnt1 = exp_cnt1 + 2'd1; else set1 = 1'b1;
        void'(sb.pop_front());
        stage = 0;
        chk_edge = 1'b1;
      end else begin
        chk("idle_jk0", 32'({j0, k0}), 32'd0);
        chk("idle_jk1", 32'({j1, k1}), 32'd0);
        chk("idle_ready", 32'({rdy0, rdy1}), 32'b11);
      end
      exp_done = chk_edge;
      if (set0) exp_err0 = 1'b1; else if (err_clr) exp_err0 = 1'b0;
      if (set1) exp_err1 = 1'b1; else if (err_clr) exp_err1 = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt = 4'b0000; err_clr = 1'b0; stuck = 4'b0000;
    idle(3);
    rst = 1'b0;

    // Set/reset mapping from 0000: 1010 then 0110.
    send(4'b1010, 1'b0, 1'b0);
    send(4'b0110, 1'b0, 1'b0);
    // Reach 1100, then toggle mapping case 1100 -> 0101.
    send(4'b1100, 1'b0, 1'b0);
    send(4'b0101, 1'b0, 1'b0);
    idle(3);

    // Reset arrives during DRIVE of 1111.
    send(4'b1111, 1'b0, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Readback bit 2 stuck at 0: mismatch, sticky err, then clear.
    stuck = 4'b0100;
    send(4'b0100, 1'b0, 1'b0);
    idle(4);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(2);

    // Clear requested on the same edge as a new mismatch: err stays set.
    send(4'b0100, 1'b0, 1'b0);
    idle(0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(3);
    stuck = 4'b0000;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(1);

    // Streaming: valid held high across five random targets.
    for (int i = 0; i < 5; i++) begin
      send(4'($urandom), (i < 4), (i > 0));
    end
    idle(3);

    // Randomized traffic with gaps, occasional clears and stuck readback bits.
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        err_clr = ($urandom_range(0, 2) == 0);
        idle(1);
      end
      err_clr = 1'b0;
      stuck = ($urandom_range(0, 4) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      send(4'($urandom), 1'b0, 1'b0);
      idle(2);
    end
    stuck = 4'b0000;
    idle(4);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_excite_gen.md
Name: jk_excite_gen

Overview:
- Inverse of the SR-to-JK conversion. It accepts target register words and generates per-bit J/K excitation for an external bank of WIDTH JK flip-flops.
- It reads back the flip-flop outputs and confirms each transition landed.
- It sits between a state sequencer and a jk-flop register bank, and serves as stimulus engine and self-checker for flip-flop conversion blocks.

Parameters:
- WIDTH, 4, number of JK flip-flops driven (1..32)
- USE_TOGGLE, 0, 1 = drive j=k=1 for changing bits; 0 = drive set/reset excitation
- CNT_W, 8, width of completed-transfer counter

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank
- rst  input  1  synchronous active-high reset
- tgt  input  WIDTH  requested next state of the JK bank
- tgt_valid  input  1  tgt is valid this cycle
- tgt_ready  output  1  block can accept tgt
- j  output  WIDTH  J excitation to the JK bank
- k  output  WIDTH  K excitation to the JK bank
- q_fb  input  WIDTH  Q outputs read back from the JK bank
- done  output  1  one-cycle pulse; transfer verified
- err  output  1  sticky mismatch flag
- err_clr  input  1  clears err (synchronous)
- xfer_cnt  output  CNT_W  count of verified transfers, wraps

Behaviour:
- Reset (rst=1 at a clk edge) forces the following. It overrides any in-flight transfer, which is discarded with no done and no count.
  - state=IDLE
  - j=0, k=0 (hold)
  - tgt_ready=0 during reset, then 1 in IDLE
  - done=0, err=0, xfer_cnt=0
  - internal tgt_q=0
- Handshake: a transfer is accepted when tgt_valid && tgt_ready at a clk edge; tgt is captured into tgt_q. tgt_ready=1 only in IDLE. tgt_valid while not ready is ignored; the sender holds it.
- FSM:
  - IDLE -> DRIVE on accept.
  - DRIVE lasts one cycle:
    - j/k are driven from tgt_q vs q_fb sampled that cycle.
    - The JK bank updates at the end of the cycle.
    - DRIVE -> CHECK.
  - CHECK lasts one cycle:
    - j=k=0.
    - Compare q_fb to tgt_q.
    - CHECK -> IDLE.
- Excitation per bit i, in DRIVE (cur=q_fb[i], nxt=tgt_q[i]):
  - 0->0: j=0, k=0.
  - 1->1: j=0, k=0.
  - 0->1: j=1, k=0, or j=1, k=1 if USE_TOGGLE.
  - 1->0: j=0, k=1, or j=1, k=1 if USE_TOGGLE.
  - j/k are registered outputs. They are asserted only during DRIVE and are 0 in all other states.
- Check and latency:
  - Accept at edge E. j/k are valid for cycle E..E+1. The comparison is made in the cycle after E+1.
  - done pulses for exactly one cycle after the CHECK cycle, coincident with tgt_ready returning to 1.
  - On match: done=1 and xfer_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - On mismatch: done=1, err<=1, and xfer_cnt does not increment.
- Minimum transfer period is 3 cycles (accept, drive, check). Back-to-back acceptance is allowed on the cycle done is high.
- err_clr:
  - Clears err at the next edge.
  - If a mismatch is detected on the same edge, set wins and err stays 1.
- A target equal to the current q_fb is legal: j=k=0 for all bits, and the transfer completes normally.
- X on q_fb is not handled; the bench must keep it defined.

Decomposition:
- Shared package ff_pkg holds:
  - the state enum {IDLE, DRIVE, CHECK}
  - the localparams for excitation encodings HOLD=2'b00, SET=2'b10, RST=2'b01, TOG=2'b11 as {j,k}
- One natural sub-module, jk_excite_bit:
  - combinational per-bit mapping (cur, nxt, USE_TOGGLE) -> {j,k}
  - instantiated WIDTH times in a generate loop
- Top level holds the FSM, capture register, checker and counter.

Test Plan:
- Reset mid-DRIVE:
  - Stimulus: assert rst during DRIVE of tgt=4'b1111.
  - Required: the next cycle shows j=k=0, tgt_ready=0 while rst=1, no done, xfer_cnt=0, err=0.
- Set/reset mapping, USE_TOGGLE=0, with a behavioural JK bank fed back:
  - Stimulus: q=4'b0000, send tgt=4'b1010, then tgt=4'b0110.
  - First DRIVE required: j=1010, k=0000.
  - Second DRIVE required: j=0100, k=1000.
  - Required: done twice, err=0, xfer_cnt=2.
- Toggle mapping, USE_TOGGLE=1:
  - Stimulus: q=4'b1100, send tgt=4'b0101.
  - Required: DRIVE j=k=1001; q_fb becomes 0101; done=1, err=0.
- Fault injection:
  - Stimulus: force q_fb[2] stuck at 0, send tgt=4'b0100.
  - Required: done pulses, err=1 and sticky, xfer_cnt unchanged.
  - Stimulus: err_clr=1 for one cycle.
  - Required: err=0.
- Back-to-back streaming:
  - Stimulus: tgt_valid held high with 5 queued targets.
  - Required: accepts 3 cycles apart, each done aligned with tgt_ready=1, and j=k=0 outside DRIVE.
- Counter wrap, CNT_W=2:
  - Stimulus: 5 matching transfers.
  - Required: xfer_cnt sequence 1,2,3,0,1.
- Simultaneous mismatch and clear:
  - Stimulus: err_clr=1 on the same edge as a mismatch.
  - Required: err=1.
